// File: rtl/ram_copy_engine.sv
// Word-copy / fill bus initiator for a 16K x 16 single-port RAM.
// One transfer at a time behind a start/busy/done handshake; it drives every RAM port signal.
module ram_copy_engine #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic              mem_e,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w,
  output logic              mem_r,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  src_ptr, dst_ptr;
  logic [LEN_W-1:0]   remaining;
  logic [DATA_W-1:0]  data_reg, fill_reg;
  logic               last_word;

  assign last_word = (remaining == LEN_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output and the next state get a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_e    = 1'b0;
    mem_r    = 1'b0;
    mem_w    = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)  state_nx = S_DONE;
          else if (mode)  state_nx = S_FILL;
          else            state_nx = S_RD;
        end
      end
      S_RD: begin
        busy     = 1'b1;
        mem_e    = 1'b1;
        mem_r    = 1'b1;
        mem_addr = src_ptr;
        state_nx = S_WR;
      end
      S_WR: begin
        busy     = 1'b1;
        mem_e    = 1'b1;
        mem_w    = 1'b1;
        mem_addr = dst_ptr;
        mem_din  = data_reg;
        state_nx = last_word ? S_DONE : S_RD;
      end
      S_FILL: begin
        busy     = 1'b1;
        mem_e    = 1'b1;
        mem_w    = 1'b1;
        mem_addr = dst_ptr;
        mem_din  = fill_reg;
        state_nx = last_word ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pointers wrap naturally at ADDR_W bits; inputs are only looked at in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_reg  <= '0;
      fill_reg  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len;
            fill_reg  <= fill_val;
          end
        end
        S_RD: begin
          data_reg <= mem_dout;
          src_ptr  <= src_ptr + 1'b1;
        end
        S_WR, S_FILL: begin
          dst_ptr   <= dst_ptr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench for ram_copy_engine: behavioural RAM, transfer-level model
// expanded into an expected bus-cycle list, and a per-cycle compare process.
module tb_ram_copy_engine;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 15;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int QN     = 1024;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              r;
    logic              w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } cyc_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] fill_val = '0;
  logic              busy, done, mem_e, mem_w, mem_r;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  cyc_t              exp_q   [QN];
  int                head = 0;
  int                tail = 0;
  logic              last_idle = 1'b1;

  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;
  logic              sync_req = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_busy = 0, cnt_done = 0, cnt_w = 0, cnt_r = 0;

  ram_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done), .mem_e(mem_e), .mem_addr(mem_addr),
    .mem_w(mem_w), .mem_r(mem_r), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem_r ? ram[mem_addr] : 'x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Environment RAM plus the transfer model: a start accepted in IDLE is expanded,
  // word by word against ref_mem, into the list of bus cycles it must produce.
  always @(posedge clk) begin
    if (mem_e && mem_w) ram[mem_addr] <= mem_din;
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
      ref_mem[pl_addr] = pl_data;
    end
    if (sync_req) for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];
    if (!rst && start && last_idle) begin
      logic [ADDR_W-1:0] s, d;
      logic [DATA_W-1:0] v;
      s = src_addr;
      d = dst_addr;
      for (int i = 0; i < int'(len); i++) begin
        if (!mode) begin
          v = ref_mem[s];
          exp_q[tail % QN] = '{busy: 1'b1, done: 1'b0, r: 1'b1, w: 1'b0, addr: s, din: '0};
          tail++;
          s = s + 1'b1;
        end else begin
          v = fill_val;
        end
        exp_q[tail % QN] = '{busy: 1'b1, done: 1'b0, r: 1'b0, w: 1'b1, addr: d, din: v};
        tail++;
        ref_mem[d] = v;
        d = d + 1'b1;
      end
      exp_q[tail % QN] = '{busy: 1'b0, done: 1'b1, r: 1'b0, w: 1'b0, addr: '0, din: '0};
      tail++;
    end
  end

  // Compare process: every out-of-reset cycle is checked against the expected list,
  // or against an idle bus when nothing is outstanding.
  always @(negedge clk) begin
    if (rst) begin
      head = tail;
      last_idle = 1'b1;
    end else begin
      cnt_busy += int'(busy);
      cnt_done += int'(done);
      cnt_w    += int'(mem_w);
      cnt_r    += int'(mem_r);
      if (head != tail) begin
        cyc_t c;
        c = exp_q[head % QN];
        head++;
        last_idle = 1'b0;
        check("cyc_busy", 32'(busy), 32'(c.busy));
        check("cyc_done", 32'(done), 32'(c.done));
        check("cyc_e", 32'(mem_e), 32'(c.r | c.w));
        check("cyc_r", 32'(mem_r), 32'(c.r));
        check("cyc_w", 32'(mem_w), 32'(c.w));
        if (c.r || c.w) check("cyc_addr", 32'(mem_addr), 32'(c.addr));
        if (c.w) check("cyc_din", 32'(mem_din), 32'(c.din));
      end else begin
        last_idle = 1'b1;
        check("idle_bus", {27'd0, busy, done, mem_e, mem_r, mem_w}, 32'd0);
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic kick(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                      input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] f);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  int b0, d0, w0, r0;
  task automatic snap();
    b0 = cnt_busy; d0 = cnt_done; w0 = cnt_w; r0 = cnt_r;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    #1;
    check("rst_outputs", {27'd0, busy, done, mem_e, mem_r, mem_w}, 32'd0);
    check("rst_addr_din", {2'd0, mem_addr, mem_din}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: plain copy
    preload(14'h0100, 16'h00A1); preload(14'h0101, 16'h00B2);
    preload(14'h0102, 16'h00C3); preload(14'h0103, 16'h00D4);
    snap();
    kick(1'b0, 14'h0100, 14'h2000, 15'd4, 16'h0);
    wait_done("copy4", 40);
    check("copy4_busy_cycles", 32'(cnt_busy - b0), 32'd8);
    check("copy4_done_pulses", 32'(cnt_done - d0), 32'd1);
    check("copy4_dst0", 32'(ram[14'h2000]), 32'h00A1);
    check("copy4_dst3", 32'(ram[14'h2003]), 32'h00D4);
    check("copy4_model_dst1", 32'(ref_mem[14'h2001]), 32'h00B2);
    check("copy4_src_kept", {ram[14'h0100], ram[14'h0103]}, 32'h00A1_00D4);

    // 2: fill across the top of the address space
    preload(14'h0002, 16'h7777);
    snap();
    kick(1'b1, 14'h0, 14'h3FFE, 15'd4, 16'h5A5A);
    wait_done("fill_wrap", 40);
    check("fill_wrap_busy_cycles", 32'(cnt_busy - b0), 32'd4);
    check("fill_wrap_3ffe_3fff", {ram[14'h3FFE], ram[14'h3FFF]}, 32'h5A5A_5A5A);
    check("fill_wrap_0000_0001", {ram[14'h0000], ram[14'h0001]}, 32'h5A5A_5A5A);
    check("fill_wrap_0002_kept", 32'(ram[14'h0002]), 32'h7777);
    check("fill_wrap_model_0001", 32'(ref_mem[14'h0001]), 32'h5A5A);

    // 3: zero length
    snap();
    kick(1'b0, 14'h0100, 14'h0200, 15'd0, 16'h0);
    check("len0_done_next", 32'(done), 32'd1);
    wait_done("len0", 5);
    check("len0_strobes", 32'((cnt_w - w0) + (cnt_r - r0)), 32'd0);
    check("len0_busy_cycles", 32'(cnt_busy - b0), 32'd0);
    check("len0_done_pulses", 32'(cnt_done - d0), 32'd1);

    // 4: overlapping copy replicates the first word
    preload(14'h0010, 16'h1234); preload(14'h0011, 16'h1111);
    preload(14'h0012, 16'h2222); preload(14'h0013, 16'h3333);
    kick(1'b0, 14'h0010, 14'h0011, 15'd3, 16'h0);
    wait_done("overlap", 40);
    check("overlap_0011", 32'(ram[14'h0011]), 32'h1234);
    check("overlap_0012", 32'(ram[14'h0012]), 32'h1234);
    check("overlap_0013", 32'(ram[14'h0013]), 32'h1234);
    check("overlap_model_0013", 32'(ref_mem[14'h0013]), 32'h1234);

    // 5: long fill with a start pulse ignored mid-transfer
    preload(14'h0564, 16'h4444);
    snap();
    kick(1'b1, 14'h0, 14'h0500, 15'd100, 16'hBEEF);
    repeat (9) @(posedge clk);
    kick(1'b0, 14'h0010, 14'h0600, 15'd5, 16'h9999);
    wait_done("fill100", 300);
    check("fill100_writes", 32'(cnt_w - w0), 32'd100);
    check("fill100_done_pulses", 32'(cnt_done - d0), 32'd1);
    check("fill100_first_last", {ram[14'h0500], ram[14'h0563]}, 32'hBEEF_BEEF);
    check("fill100_past_end", 32'(ram[14'h0564]), 32'h4444);
    check("fill100_ignored_start", 32'(ram[14'h0600]), 32'h0000);

    // 6: reset in the middle of a copy
    for (int i = 0; i < 8; i++) preload(14'h0200 + 14'(i), 16'hC000 + 16'(i));
    snap();
    kick(1'b0, 14'h0200, 14'h0300, 15'd8, 16'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_outputs", {27'd0, busy, done, mem_e, mem_r, mem_w}, 32'd0);
    check("midrst_addr_din", {2'd0, mem_addr, mem_din}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(cnt_done - d0), 32'd0);
    @(negedge clk);
    sync_req = 1'b1;
    @(posedge clk);
    #1 sync_req = 1'b0;
    kick(1'b0, 14'h0200, 14'h0400, 15'd3, 16'h0);
    wait_done("after_rst", 40);
    check("after_rst_0400", 32'(ram[14'h0400]), 32'hC000);
    check("after_rst_0402", 32'(ram[14'h0402]), 32'hC002);
    check("after_rst_done_pulses", 32'(cnt_done - d0), 32'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
